// File: rtl/pc_seq_pkg.sv
// Shared constants and state type for the program-counter sequencer.
package pc_seq_pkg;

  localparam int PC_W          = 10;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_depth_ctr.sv
// Return-stack occupancy counter with sticky overflow/underflow flags.
// Only instantiated when DEPTH_CHECK_EN is defined.
module pc_depth_ctr
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  logic ovf_set_i,
  input  logic unf_set_i,
  output logic full_o,
  output logic empty_o,
  output logic ovf_o,
  output logic unf_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  assign full_o  = (depth_q == CW'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  // The sequencer already suppresses push when full and pop when empty,
  // so the saturation guards here are only a safety net.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q | ovf_set_i;
    unf_d   = unf_q | unf_set_i;
    if (push_i && !full_o) begin
      depth_d = depth_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with call/return support via an external stack.
// Optional call-depth checking is enabled by defining DEPTH_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 10'd0,
  parameter int              DEPTH    = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic            cjump,
  input  logic            zero,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] ret_addr,
  output logic [PC_W-1:0] pc,
  output logic            push,
  output logic            pop,
  output logic [PC_W-1:0] inpush,
  output logic            busy,
  output logic            ovf,
  output logic            unf
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            push_c, pop_c;

`ifdef DEPTH_CHECK_EN
  logic full, empty;
  logic ovf_set, unf_set;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
`ifdef DEPTH_CHECK_EN
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    unique case (state_q)
      RUN: begin
        if (en) begin
          if (ret) begin
`ifdef DEPTH_CHECK_EN
            if (empty) begin
              unf_set = 1'b1;
              pc_d    = pc_q + PC_W'(1);
            end else
`endif
            begin
              pop_c   = 1'b1;
              state_d = RET_WAIT;
            end
          end else if (call) begin
            pc_d = target;
`ifdef DEPTH_CHECK_EN
            if (full) ovf_set = 1'b1;
            else      push_c  = 1'b1;
`else
            push_c = 1'b1;
`endif
          end else if (jump || (cjump && zero)) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      // The stack's registered output is valid now; load it unconditionally.
      RET_WAIT: begin
        pc_d    = ret_addr;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Stack strobes are forced low while reset is held so the stack cannot
  // be disturbed by command inputs during reset.
  assign push   = push_c & reset;
  assign pop    = pop_c & reset;
  assign pc     = pc_q;
  assign inpush = pc_q;
  assign busy   = (state_q == RET_WAIT);

`ifdef DEPTH_CHECK_EN
  pc_depth_ctr #(
    .DEPTH (DEPTH)
  ) u_depth_ctr (
    .clk_i     (clk),
    .rst_ni    (reset),
    .push_i    (push),
    .pop_i     (pop),
    .ovf_set_i (ovf_set),
    .unf_set_i (unf_set),
    .full_o    (full),
    .empty_o   (empty),
    .ovf_o     (ovf),
    .unf_o     (unf)
  );
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random commands
// checked against a stack-based reference model.
module tb_pc_sequencer;

  localparam int DEPTH = 16;
`ifdef DEPTH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       en, jump, call, ret, cjump, zero;
  logic [9:0] target, ret_addr;
  logic [9:0] pc, inpush;
  logic       push, pop, busy, ovf, unf;

  pc_sequencer #(
    .RESET_PC (10'd0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .jump     (jump),
    .call     (call),
    .ret      (ret),
    .cjump    (cjump),
    .zero     (zero),
    .target   (target),
    .ret_addr (ret_addr),
    .pc       (pc),
    .push     (push),
    .pop      (pop),
    .inpush   (inpush),
    .busy     (busy),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] pc;
    logic [9:0] inpush;
    logic       push;
    logic       pop;
    logic       busy;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the return stack is a plain queue, call depth is its size.
  logic [9:0] mPc;
  logic       mWait;
  logic       mOvf, mUnf;
  logic [9:0] mRetAddr;
  logic [9:0] stack[$];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("pc", pc, e.pc);
    check("inpush", inpush, e.inpush);
    check("push", {9'd0, push}, {9'd0, e.push});
    check("pop", {9'd0, pop}, {9'd0, e.pop});
    check("busy", {9'd0, busy}, {9'd0, e.busy});
    check("ovf", {9'd0, ovf}, {9'd0, e.ovf});
    check("unf", {9'd0, unf}, {9'd0, e.unf});
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    {en, jump, call, ret, cjump, zero} = '0;
    target   = 10'($urandom);
    ret_addr = 10'($urandom);
    mPc   = 10'd0;
    mWait = 1'b0;
    mOvf  = 1'b0;
    mUnf  = 1'b0;
    stack.delete();
    expQ.push_back('{pc: 10'd0, inpush: 10'd0, push: 1'b0, pop: 1'b0,
                     busy: 1'b0, ovf: 1'b0, unf: 1'b0});
  endtask

  task automatic applyStimulus(input logic e, input logic j, input logic c,
                               input logic r, input logic cj, input logic z,
                               input logic [9:0] t);
    exp_t       x;
    logic [9:0] nPc;
    logic       nWait;
    logic       nOvf, nUnf;
    @(posedge clk);
    #1;
    reset = 1'b1;
    en = e; jump = j; call = c; ret = r; cjump = cj; zero = z;
    target   = t;
    ret_addr = mWait ? mRetAddr : 10'($urandom);
    x = '{pc: mPc, inpush: mPc, push: 1'b0, pop: 1'b0,
          busy: mWait, ovf: mOvf, unf: mUnf};
    nPc = mPc; nWait = 1'b0; nOvf = mOvf; nUnf = mUnf;
    if (mWait) begin
      nPc = mRetAddr;
    end else if (e) begin
      if (r) begin
        if (CHK && stack.size() == 0) begin
          nUnf = 1'b1;
          nPc  = mPc + 10'd1;
        end else begin
          x.pop    = 1'b1;
          nWait    = 1'b1;
          mRetAddr = (stack.size() > 0) ? stack.pop_back() + 10'd1 : 10'($urandom);
        end
      end else if (c) begin
        nPc = t;
        if (CHK && stack.size() == DEPTH) begin
          nOvf = 1'b1;
        end else begin
          x.push = 1'b1;
          stack.push_back(mPc);
        end
      end else if (j || (cj && z)) begin
        nPc = t;
      end else begin
        nPc = mPc + 10'd1;
      end
    end
    expQ.push_back(x);
    mPc = nPc; mWait = nWait; mOvf = nOvf; mUnf = nUnf;
  endtask

  initial begin
    reset = 1'b0;
    {en, jump, call, ret, cjump, zero} = '0;
    target = '0; ret_addr = '0;
    mPc = '0; mWait = 1'b0; mOvf = 1'b0; mUnf = 1'b0; mRetAddr = '0;

    applyReset();
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 10'h0);
    applyStimulus(1, 1, 0, 0, 0, 0, 10'd5);
    applyStimulus(1, 0, 1, 0, 0, 0, 10'h40);
    applyStimulus(1, 1, 0, 0, 0, 0, 10'h42);
    applyStimulus(1, 0, 0, 1, 0, 0, 10'h77);
    applyStimulus(1, 1, 1, 1, 1, 1, 10'h123);
    applyStimulus(0, 0, 0, 0, 0, 0, 10'h0);
    applyStimulus(0, 1, 1, 1, 0, 0, 10'h55);
    applyStimulus(1, 1, 0, 0, 0, 0, 10'h3FF);
    applyStimulus(1, 0, 0, 0, 0, 0, 10'h0);
    applyStimulus(1, 0, 0, 0, 1, 0, 10'h10);
    applyStimulus(1, 0, 0, 0, 1, 1, 10'h10);
    applyStimulus(1, 0, 1, 0, 0, 0, 10'h200);
    applyStimulus(1, 0, 1, 1, 0, 0, 10'h300);
    applyStimulus(1, 0, 0, 0, 0, 0, 10'h0);
    applyStimulus(1, 0, 1, 0, 0, 0, 10'h2A0);
    applyStimulus(1, 0, 0, 1, 0, 0, 10'h0);
    applyReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 10'h0);

    applyReset();
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, 0, 1, 0, 0, 0, 10'($urandom));
    applyStimulus(1, 0, 0, 0, 0, 0, 10'h0);
    applyReset();
    applyStimulus(1, 0, 0, 1, 0, 0, 10'h0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 10'h0);

    applyReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) applyReset();
      else applyStimulus($urandom_range(0, 5) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                         $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                         10'($urandom));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
